// File: rtl/exu_csr_seq_unit_if.sv
// Bundle of the dispatch request, CSR file and writeback ports of exu_csr_seq_unit.
// The slave modport is the unit side and the master modport is the environment side.
interface exu_csr_seq_unit_if #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12,
  parameter int REG_ADDR_W = 5
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [1:0]            req_op_i;
  logic [XLEN-1:0]       req_op1_i;
  logic                  req_op1_zero_i;
  logic [CSR_ADDR_W-1:0] req_addr_i;
  logic [REG_ADDR_W-1:0] req_rd_i;
  logic                  int_assert_i;
  logic [CSR_ADDR_W-1:0] csr_raddr_o;
  logic [XLEN-1:0]       csr_rdata_i;
  logic                  csr_we_o;
  logic [CSR_ADDR_W-1:0] csr_waddr_o;
  logic [XLEN-1:0]       csr_wdata_o;
  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [REG_ADDR_W-1:0] wb_rd_o;
  logic [XLEN-1:0]       wb_data_o;
  logic                  busy_o;
  logic                  illegal_o;

  modport slave (
    input  req_valid_i, req_op_i, req_op1_i, req_op1_zero_i, req_addr_i, req_rd_i,
    input  int_assert_i, csr_rdata_i, wb_ready_i,
    output req_ready_o, csr_raddr_o, csr_we_o, csr_waddr_o, csr_wdata_o,
    output wb_valid_o, wb_rd_o, wb_data_o, busy_o, illegal_o
  );

  modport master (
    output req_valid_i, req_op_i, req_op1_i, req_op1_zero_i, req_addr_i, req_rd_i,
    output int_assert_i, csr_rdata_i, wb_ready_i,
    input  req_ready_o, csr_raddr_o, csr_we_o, csr_waddr_o, csr_wdata_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, busy_o, illegal_o
  );
endinterface

// File: rtl/exu_csr_seq_unit.sv
// Sequenced CSRRW/CSRRS/CSRRC unit: IDLE -> READ -> WRITE -> RESP with registered outputs.
// Optional macro CSR_RO_TRAP_EN turns writes to read-only CSRs (addr[11:10]==2'b11) into an illegal_o pulse.
module exu_csr_seq_unit #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12,
  parameter int REG_ADDR_W = 5
) (
  input logic              clk,
  input logic              rst_n,
  exu_csr_seq_unit_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RC = 2'b11;

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [XLEN-1:0]       op1_q, op1_d;
  logic                  op1_zero_q, op1_zero_d;
  logic [CSR_ADDR_W-1:0] addr_q, addr_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       old_q, old_d;

  logic                  ready_q, ready_d;
  logic [CSR_ADDR_W-1:0] raddr_q, raddr_d;
  logic                  we_q, we_d;
  logic [CSR_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic                  busy_q, busy_d;
  logic                  illegal_q, illegal_d;

  logic [XLEN-1:0]       new_val_s;
  logic                  suppress_s;
  logic                  ro_trap_s;

  // New CSR value and write qualification, evaluated against the live read data in READ.
  always_comb begin
    case (op_q)
      OP_RW:   new_val_s = op1_q;
      OP_RC:   new_val_s = bus.csr_rdata_i & ~op1_q;
      default: new_val_s = bus.csr_rdata_i | op1_q;
    endcase
    suppress_s = (op_q != OP_RW) && op1_zero_q;
`ifdef CSR_RO_TRAP_EN
    ro_trap_s = (addr_q[CSR_ADDR_W-1 -: 2] == 2'b11) && !suppress_s;
`else
    ro_trap_s = 1'b0;
`endif
  end

  // Next-state logic; output registers are loaded with the value they must show in the next state.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    op1_d      = op1_q;
    op1_zero_d = op1_zero_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    old_d      = old_q;
    ready_d    = 1'b0;
    raddr_d    = '0;
    we_d       = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;
    wb_valid_d = 1'b0;
    wb_rd_d    = '0;
    wb_data_d  = '0;
    illegal_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i && ready_q) begin
          op_d       = bus.req_op_i;
          op1_d      = bus.req_op1_i;
          op1_zero_d = bus.req_op1_zero_i;
          addr_d     = bus.req_addr_i;
          rd_d       = bus.req_rd_i;
          raddr_d    = bus.req_addr_i;
          state_d    = ST_READ;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_READ: begin
        if (bus.int_assert_i) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          old_d     = bus.csr_rdata_i;
          we_d      = !suppress_s && !ro_trap_s;
          illegal_d = ro_trap_s;
          waddr_d   = addr_q;
          wdata_d   = new_val_s;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Committed: interrupts no longer matter; x0 results and traps produce no writeback.
        if (!illegal_q && (rd_q != '0)) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = old_q;
          state_d    = ST_RESP;
        end else begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (bus.wb_ready_i) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = old_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, request and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= 2'b00;
      op1_q      <= '0;
      op1_zero_q <= 1'b0;
      addr_q     <= '0;
      rd_q       <= '0;
      old_q      <= '0;
      ready_q    <= 1'b0;
      raddr_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      busy_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      op1_q      <= op1_d;
      op1_zero_q <= op1_zero_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      old_q      <= old_d;
      ready_q    <= ready_d;
      raddr_q    <= raddr_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      busy_q     <= busy_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.csr_raddr_o = raddr_q;
  assign bus.csr_we_o    = we_q;
  assign bus.csr_waddr_o = waddr_q;
  assign bus.csr_wdata_o = wdata_q;
  assign bus.wb_valid_o  = wb_valid_q;
  assign bus.wb_rd_o     = wb_rd_q;
  assign bus.wb_data_o   = wb_data_q;
  assign bus.busy_o      = busy_q;
  assign bus.illegal_o   = illegal_q;
endmodule

// File: tb/tb_exu_csr_seq_unit.sv
// Bench for exu_csr_seq_unit: directed vector table, reset/abort sequences and
// randomized transactions checked against an instruction-level CSR model.
module tb_exu_csr_seq_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exu_csr_seq_unit_if #(.XLEN(32), .CSR_ADDR_W(12), .REG_ADDR_W(5)) bus ();

  exu_csr_seq_unit #(.XLEN(32), .CSR_ADDR_W(12), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [31:0] csr_mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  int n_cmp = 0;
  int n_err = 0;

  // Bench-side CSR file: combinational read, write on the strobe.
  assign bus.csr_rdata_i = csr_mem[bus.csr_raddr_o];
  always @(posedge clk) begin
    if (bus.csr_we_o === 1'b1) csr_mem[bus.csr_waddr_o] = bus.csr_wdata_o;
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] op1;
    logic        z;
    logic [11:0] addr;
    logic [4:0]  rd;
    logic [31:0] pre;
    int          int_cyc;
    int          stall;
    int          e_we;
    logic [31:0] e_wdata;
    int          e_wb;
    int          e_ready;
    int          e_ill;
  } vec_t;

  typedef struct {
    int          we_cnt;
    logic [11:0] waddr;
    logic [31:0] wdata;
    int          wb_cnt;
    int          wb_lat;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    int          ready_lat;
    int          ill_cnt;
  } obs_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, output obs_t o);
    int n;
    int vcnt;
    o = '{default: 0};
    o.wb_lat = -1;
    o.ready_lat = -1;
    n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_wait", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i    = 1'b1;
    bus.req_op_i       = v.op;
    bus.req_op1_i      = v.op1;
    bus.req_op1_zero_i = v.z;
    bus.req_addr_i     = v.addr;
    bus.req_rd_i       = v.rd;
    bus.int_assert_i   = 1'b0;
    bus.wb_ready_i     = 1'b0;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    vcnt = 0;
    for (int c = 1; c <= 30; c++) begin
      if (bus.csr_we_o === 1'b1) begin
        o.we_cnt++;
        o.waddr = bus.csr_waddr_o;
        o.wdata = bus.csr_wdata_o;
      end
      if (bus.illegal_o === 1'b1) o.ill_cnt++;
      if (bus.wb_valid_o === 1'b1) begin
        if (vcnt == 0) begin
          o.wb_lat  = c;
          o.wb_data = bus.wb_data_o;
          o.wb_rd   = bus.wb_rd_o;
        end else begin
          chk("wb_data_stable", bus.wb_data_o, o.wb_data);
        end
        vcnt++;
      end
      if (bus.req_ready_o === 1'b1) begin
        o.ready_lat = c;
        break;
      end
      bus.int_assert_i = (c == v.int_cyc);
      bus.wb_ready_i   = (bus.wb_valid_o === 1'b1) && (vcnt > v.stall);
      @(negedge clk);
    end
    bus.int_assert_i = 1'b0;
    bus.wb_ready_i   = 1'b0;
    o.wb_cnt = vcnt;
  endtask

  task automatic apply_vec(input vec_t v, input bit do_pre, input string tag);
    obs_t o;
    if (do_pre) csr_mem[v.addr] = v.pre;
    run_txn(v, o);
    chk({tag, "_we_cnt"}, 32'(o.we_cnt), 32'(v.e_we));
    if (v.e_we != 0) begin
      chk({tag, "_waddr"}, 32'(o.waddr), 32'(v.addr));
      chk({tag, "_wdata"}, o.wdata, v.e_wdata);
    end
    chk({tag, "_wb_cycles"}, 32'(o.wb_cnt), (v.e_wb != 0) ? 32'(v.stall + 1) : 32'd0);
    if (v.e_wb != 0) begin
      chk({tag, "_wb_lat"}, 32'(o.wb_lat), 32'd3);
      chk({tag, "_wb_data"}, o.wb_data, v.pre);
      chk({tag, "_wb_rd"}, 32'(o.wb_rd), 32'(v.rd));
    end
    chk({tag, "_ready_lat"}, 32'(o.ready_lat), 32'(v.e_ready));
    chk({tag, "_illegal"}, 32'(o.ill_cnt), 32'(v.e_ill));
  endtask

  vec_t tbl [11];
  logic [11:0] addrs [4];

  initial begin
    vec_t v;
    logic [31:0] old;
    logic [31:0] newv;
    bit aborted;
    bit supp;
    int n;

    // op, op1, z, addr, rd, pre, int_cyc, stall, e_we, e_wdata, e_wb, e_ready, e_ill
    tbl[0]  = '{2'b01, 32'hA5A5_0000, 1'b0, 12'h340, 5'd5, 32'h0000_1234, 0, 0, 1, 32'hA5A5_0000, 1, 4, 0};
    tbl[1]  = '{2'b10, 32'h0000_0000, 1'b1, 12'h341, 5'd3, 32'h0000_0088, 0, 0, 0, 32'h0,         1, 4, 0};
    tbl[2]  = '{2'b11, 32'h0000_0008, 1'b0, 12'h341, 5'd3, 32'h0000_0088, 0, 0, 1, 32'h0000_0080, 1, 4, 0};
    tbl[3]  = '{2'b01, 32'h0000_0100, 1'b0, 12'h305, 5'd0, 32'h0000_0000, 0, 0, 1, 32'h0000_0100, 0, 3, 0};
    tbl[4]  = '{2'b01, 32'h0000_FFFF, 1'b0, 12'h300, 5'd2, 32'h0000_0011, 1, 0, 0, 32'h0,         0, 2, 0};
    tbl[5]  = '{2'b10, 32'h0000_0006, 1'b0, 12'h300, 5'd2, 32'h0000_0011, 2, 0, 1, 32'h0000_0017, 1, 4, 0};
    tbl[6]  = '{2'b11, 32'h0000_0001, 1'b0, 12'h300, 5'd7, 32'h0000_0017, 0, 5, 1, 32'h0000_0016, 1, 9, 0};
    tbl[7]  = '{2'b00, 32'h0000_0005, 1'b0, 12'h340, 5'd1, 32'hA5A5_0000, 0, 1, 1, 32'hA5A5_0005, 1, 5, 0};
    tbl[8]  = '{2'b11, 32'h0000_0000, 1'b1, 12'h340, 5'd4, 32'hA5A5_0005, 0, 0, 0, 32'h0,         1, 4, 0};
`ifdef CSR_RO_TRAP_EN
    tbl[9]  = '{2'b01, 32'h0000_0009, 1'b0, 12'hC00, 5'd6, 32'h0000_0042, 0, 0, 0, 32'h0,         0, 3, 1};
`else
    tbl[9]  = '{2'b01, 32'h0000_0009, 1'b0, 12'hC00, 5'd6, 32'h0000_0042, 0, 0, 1, 32'h0000_0009, 1, 4, 0};
`endif
    tbl[10] = '{2'b01, 32'h0000_0000, 1'b1, 12'h305, 5'd8, 32'h0000_0100, 0, 2, 1, 32'h0000_0000, 1, 6, 0};

    bus.req_valid_i    = 1'b0;
    bus.req_op_i       = 2'b00;
    bus.req_op1_i      = 32'h0;
    bus.req_op1_zero_i = 1'b0;
    bus.req_addr_i     = 12'h0;
    bus.req_rd_i       = 5'd0;
    bus.int_assert_i   = 1'b0;
    bus.wb_ready_i     = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end

    // Reset state.
    #12;
    chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_we", 32'(bus.csr_we_o), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_raddr", 32'(bus.csr_raddr_o), 32'd0);
    chk("rst_illegal", 32'(bus.illegal_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) apply_vec(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Reset asserted while the write strobe is up.
    csr_mem[12'h340] = 32'h0000_CAFE;
    n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 2'b01;
    bus.req_op1_i   = 32'h0000_0077;
    bus.req_op1_zero_i = 1'b0;
    bus.req_addr_i  = 12'h340;
    bus.req_rd_i    = 5'd9;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("midrst_read_addr", 32'(bus.csr_raddr_o), 32'h340);
    chk("midrst_busy", 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    chk("midrst_we_before", 32'(bus.csr_we_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(bus.csr_we_o), 32'd0);
    chk("midrst_waddr", 32'(bus.csr_waddr_o), 32'd0);
    chk("midrst_wdata", bus.csr_wdata_o, 32'd0);
    chk("midrst_busy_after", 32'(bus.busy_o), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.wb_valid_o === 1'b1) n++;
    end
    chk("midrst_no_wb", 32'(n), 32'd0);
    chk("midrst_ready_back", 32'(bus.req_ready_o), 32'd1);
    chk("midrst_no_write", csr_mem[12'h340], 32'h0000_CAFE);

    // Randomized transactions against the instruction-level model.
    addrs[0] = 12'h300;
    addrs[1] = 12'h305;
    addrs[2] = 12'h340;
    addrs[3] = 12'h341;
    for (int i = 0; i < 4; i++) begin
      csr_mem[addrs[i]] = $urandom;
      ref_mem[addrs[i]] = csr_mem[addrs[i]];
    end
    for (int t = 0; t < 60; t++) begin
      v.op      = 2'($urandom_range(0, 3));
      v.z       = ($urandom_range(0, 3) == 0);
      v.op1     = v.z ? 32'h0 : 32'($urandom);
      v.addr    = addrs[$urandom_range(0, 3)];
      v.rd      = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      v.int_cyc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      v.stall   = int'($urandom_range(0, 3));
      old       = ref_mem[v.addr];
      aborted   = (v.int_cyc == 1);
      supp      = (v.op != 2'b01) && v.z;
      if (v.op == 2'b01)      newv = v.op1;
      else if (v.op == 2'b11) newv = old & ~v.op1;
      else                    newv = old | v.op1;
      v.pre     = old;
      v.e_we    = (!aborted && !supp) ? 1 : 0;
      v.e_wdata = newv;
      v.e_wb    = (!aborted && v.rd != 5'd0) ? 1 : 0;
      v.e_ready = aborted ? 2 : ((v.rd != 5'd0) ? 4 + v.stall : 3);
      v.e_ill   = 0;
      if (v.e_we != 0) ref_mem[v.addr] = newv;
      apply_vec(v, 1'b0, $sformatf("rnd%0d", t));
    end
    for (int i = 0; i < 4; i++) chk($sformatf("final_csr%0d", i), csr_mem[addrs[i]], ref_mem[addrs[i]]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
